// File: rtl/pwm_meas_sched_if.sv
// Result handshake between the PWM measurement scheduler and its consumer.
interface pwm_meas_sched_if;
    logic [31:0] result_high;
    logic [31:0] result_low;
    logic [2:0]  result_ch;
    logic        result_valid;
    logic        result_timeout;
    logic        result_ack;

    // Producer side: the measurement engine.
    modport master (
        output result_high,
        output result_low,
        output result_ch,
        output result_valid,
        output result_timeout,
        input  result_ack
    );

    // Consumer side.
    modport slave (
        input  result_high,
        input  result_low,
        input  result_ch,
        input  result_valid,
        input  result_timeout,
        output result_ack
    );
endinterface

// File: rtl/pwm_meas_sched.sv
// Time-shared PWM measurement engine: round-robins over enabled channels, averages high/low
// time over 2^SAMPLE_LOG2 periods and reports stuck lines via a timeout.
module pwm_meas_sched #(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned SAMPLE_LOG2    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic              pwd_clk,
    input  logic              sysreset,
    input  logic [NUM_CH-1:0] pwm_in,
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic              run,
    output logic              busy,
    pwm_meas_sched_if.master  res
);

    localparam int unsigned ACC_W = 32 + SAMPLE_LOG2;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned PER_W = SAMPLE_LOG2 + 1;
    localparam logic [PER_W-1:0] LAST_PER = PER_W'((1 << SAMPLE_LOG2) - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StSelect, StArm, StMeasure, StPresent} state_e;

    state_e             state_q;
    logic [NUM_CH-1:0]  sync1_q, sync2_q, sync3_q;
    logic [2:0]         cur_ch_q, last_ch_q;
    logic [31:0]        high_cnt_q, low_cnt_q;
    logic [ACC_W-1:0]   acc_high_q, acc_low_q;
    logic [PER_W-1:0]   per_q;
    logic [TMO_W-1:0]   tmo_q;
    logic [31:0]        result_high_q, result_low_q;
    logic [2:0]         result_ch_q;
    logic               result_valid_q, result_timeout_q;

    logic               sel_now, sel_prev, rise, tmo_hit;
    logic               found_hi;
    logic [2:0]         nxt_hi, nxt_any, nxt_ch;
    logic [ACC_W-1:0]   sum_high, sum_low;
    logic [31:0]        avg_high, avg_low;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Two-flop synchronizers plus one history stage for edge detection.
    always_ff @(posedge pwd_clk or negedge sysreset) begin
        if (!sysreset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // Mux the selected channel's synchronized level and its previous value.
    always_comb begin
        sel_now  = 1'b0;
        sel_prev = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cur_ch_q == 3'(i)) begin
                sel_now  = sync2_q[i];
                sel_prev = sync3_q[i];
            end
        end
    end

    assign rise    = sel_now & ~sel_prev;
    assign tmo_hit = (tmo_q == TMO_LAST);

    // Round-robin pick: lowest enabled channel above the last one, else lowest enabled overall.
    always_comb begin
        found_hi = 1'b0;
        nxt_hi   = '0;
        nxt_any  = '0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (ch_enable[j]) begin
                nxt_any = 3'(j);
                if (3'(j) > last_ch_q) begin
                    found_hi = 1'b1;
                    nxt_hi   = 3'(j);
                end
            end
        end
        nxt_ch = found_hi ? nxt_hi : nxt_any;
    end

    // Accumulator totals including the period closed by the current rising edge.
    always_comb begin
        sum_high = acc_high_q + ACC_W'(high_cnt_q);
        sum_low  = acc_low_q + ACC_W'(low_cnt_q);
        avg_high = 32'(sum_high >> SAMPLE_LOG2);
        avg_low  = 32'(sum_low >> SAMPLE_LOG2);
    end

    // Scheduler FSM with all counters and registered result outputs.
    always_ff @(posedge pwd_clk or negedge sysreset) begin
        if (!sysreset) begin
            state_q          <= StIdle;
            cur_ch_q         <= '0;
            last_ch_q        <= 3'(NUM_CH - 1);
            high_cnt_q       <= '0;
            low_cnt_q        <= '0;
            acc_high_q       <= '0;
            acc_low_q        <= '0;
            per_q            <= '0;
            tmo_q            <= '0;
            result_high_q    <= '0;
            result_low_q     <= '0;
            result_ch_q      <= '0;
            result_valid_q   <= 1'b0;
            result_timeout_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (run && (ch_enable != '0)) state_q <= StSelect;
                end
                StSelect: begin
                    if (!run || (ch_enable == '0)) begin
                        state_q <= StIdle;
                    end else begin
                        cur_ch_q   <= nxt_ch;
                        last_ch_q  <= nxt_ch;
                        high_cnt_q <= '0;
                        low_cnt_q  <= '0;
                        acc_high_q <= '0;
                        acc_low_q  <= '0;
                        per_q      <= '0;
                        tmo_q      <= '0;
                        state_q    <= StArm;
                    end
                end
                StArm, StMeasure: begin
                    if (!run) begin
                        state_q <= StIdle;
                    end else if (rise) begin
                        // The edge cycle is the first high cycle of the new period.
                        high_cnt_q <= 32'd1;
                        low_cnt_q  <= '0;
                        tmo_q      <= '0;
                        if (state_q == StArm) begin
                            state_q <= StMeasure;
                        end else if (per_q == LAST_PER) begin
                            result_high_q    <= avg_high;
                            result_low_q     <= avg_low;
                            result_ch_q      <= cur_ch_q;
                            result_timeout_q <= 1'b0;
                            result_valid_q   <= 1'b1;
                            state_q          <= StPresent;
                        end else begin
                            acc_high_q <= sum_high;
                            acc_low_q  <= sum_low;
                            per_q      <= per_q + 1'b1;
                        end
                    end else if (tmo_hit) begin
                        result_high_q    <= sel_now ? 32'hFFFF_FFFF : 32'd0;
                        result_low_q     <= sel_now ? 32'd0 : 32'hFFFF_FFFF;
                        result_ch_q      <= cur_ch_q;
                        result_timeout_q <= 1'b1;
                        result_valid_q   <= 1'b1;
                        state_q          <= StPresent;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                        if (state_q == StMeasure) begin
                            if (sel_now) high_cnt_q <= sat_inc(high_cnt_q);
                            else         low_cnt_q  <= sat_inc(low_cnt_q);
                        end
                    end
                end
                StPresent: begin
                    if (res.result_ack) begin
                        result_valid_q <= 1'b0;
                        state_q        <= run ? StSelect : StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy               = (state_q != StIdle);
    assign res.result_high    = result_high_q;
    assign res.result_low     = result_low_q;
    assign res.result_ch      = result_ch_q;
    assign res.result_valid   = result_valid_q;
    assign res.result_timeout = result_timeout_q;

endmodule
